// File: rtl/ula_pkg.sv
// Shared definitions for the ULA and its command/result sequencer:
// operand width, op_sel codes and the sequencer state encoding.
package ula_pkg;

    localparam int ULA_WIDTH = 6;

    // op_sel codes in logic mode (modo=1)
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // op_sel codes in arithmetic mode (modo=0)
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ula_sequencer.sv
// Command front end and result stage for the ULA.
// Ports: clk/reset (async, active-low); cmd_* valid/ready command in;
//   ula_* registered operands out and raw ULA results in;
//   res_* valid/ready result out; acc = last delivered result;
//   op_count = delivered results, wrapping modulo 2^CNT_W.
module ula_sequencer
    import ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_modo,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [2:0]       ula_op_sel,
    output logic             ula_modo,
    input  logic [WIDTH-1:0] ula_o,
    input  logic             ula_carry,
    input  logic             ula_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_o,
    output logic             res_carry,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    state_t           r_state;
    logic             r_cmd_ready;
    logic [WIDTH-1:0] r_ula_a;
    logic [WIDTH-1:0] r_ula_b;
    logic [2:0]       r_ula_op;
    logic             r_ula_modo;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_o;
    logic             r_res_carry;
    logic             r_res_zero;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_opa;

    assign w_opa = cmd_use_acc ? r_acc : cmd_a;

    // cmd_ready is registered, so it stays low for the first
    // cycle after reset release and no command is taken then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_ula_a     <= '0;
            r_ula_b     <= '0;
            r_ula_op    <= '0;
            r_ula_modo  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_o     <= '0;
            r_res_carry <= 1'b0;
            r_res_zero  <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (r_cmd_ready && cmd_valid) begin
                        r_ula_a     <= w_opa;
                        r_ula_b     <= cmd_b;
                        r_ula_op    <= cmd_op;
                        r_ula_modo  <= cmd_modo;
                        r_cmd_ready <= 1'b0;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    r_res_o     <= ula_o;
                    r_res_carry <= ula_carry;
                    r_res_zero  <= ula_zero;
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        r_acc       <= r_res_o;
                        r_cnt       <= r_cnt + 1'b1;
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_cmd_ready <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign ula_a      = r_ula_a;
    assign ula_b      = r_ula_b;
    assign ula_op_sel = r_ula_op;
    assign ula_modo   = r_ula_modo;
    assign res_valid  = r_res_valid;
    assign res_o      = r_res_o;
    assign res_carry  = r_res_carry;
    assign res_zero   = r_res_zero;
    assign acc        = r_acc;
    assign op_count   = r_cnt;

endmodule
